// File: rtl/fpu_sequencer_if.sv
// Issue/result bundle between the E-stage pipeline and the FPU sequencer.
// The slave side is the sequencer; the master side is the pipeline/hazard unit.
interface fpu_sequencer_if #(
  parameter int unsigned REGW = 6,
  parameter int unsigned CNTW = 16
);
  logic            issue_valid;
  logic [4:0]      issue_op;
  logic [REGW-1:0] issue_rd;
  logic            flush;
  logic [REGW-1:0] RsD;
  logic [REGW-1:0] RtD;
  logic            floatstall;
  logic            result_valid;
  logic [REGW-1:0] result_rd;
  logic            raw_hazard;
  logic            busy;
  logic [CNTW-1:0] op_count;
  logic [CNTW-1:0] stall_count;

  modport master (
    output issue_valid, issue_op, issue_rd, flush, RsD, RtD,
    input  floatstall, result_valid, result_rd, raw_hazard, busy, op_count, stall_count
  );

  modport slave (
    input  issue_valid, issue_op, issue_rd, flush, RsD, RtD,
    output floatstall, result_valid, result_rd, raw_hazard, busy, op_count, stall_count
  );
endinterface

// File: rtl/fpu_sequencer.sv
// Multi-cycle FPU sequencer: holds the pipeline for an op's latency, pulses the
// result on completion, flags D-stage RAW hazards and keeps saturating counters.
module fpu_sequencer #(
  parameter int unsigned REGW = 6,
  parameter int unsigned CNTW = 16
) (
  input logic            clk,
  input logic            rstn,
  fpu_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [2:0]      remain_q, remain_d;
  logic [REGW-1:0] pend_rd_q, pend_rd_d;
  logic [CNTW-1:0] op_count_q, stall_count_q;
  logic [2:0]      lat;
  logic            stall, res_valid;

  always_comb begin
    lat = 3'd0;
    case (bus.issue_op)
      5'b00001, 5'b00011:           lat = 3'd3;
      5'b00101, 5'b01101:           lat = 3'd2;
      5'b00111:                     lat = 3'd5;
      5'b10001, 5'b10011, 5'b10101: lat = 3'd1;
      default:                      lat = 3'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    pend_rd_d = pend_rd_q;
    stall     = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.issue_valid && lat != 3'd0) begin
          stall     = 1'b1;
          pend_rd_d = bus.issue_rd;
          if (lat >= 3'd2) begin
            remain_d = lat - 3'd1;
            state_d  = BUSY;
          end else begin
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        stall    = 1'b1;
        remain_d = remain_q - 3'd1;
        if (remain_q == 3'd1) state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over accept and completion, but the stall for this cycle stands.
    if (bus.flush) begin
      state_d   = IDLE;
      remain_d  = 3'd0;
      res_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      remain_q      <= 3'd0;
      pend_rd_q     <= '0;
      op_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      pend_rd_q <= pend_rd_d;
      if (res_valid && op_count_q != '1) op_count_q <= op_count_q + 1'b1;
      if (stall && stall_count_q != '1) stall_count_q <= stall_count_q + 1'b1;
    end
  end

  // IDLE stall depends on live issue inputs, so it is masked while in reset.
  assign bus.floatstall   = stall & rstn;
  assign bus.result_valid = res_valid;
  assign bus.result_rd    = res_valid ? pend_rd_q : '0;
  assign bus.busy         = (state_q != IDLE);
  assign bus.raw_hazard   = bus.busy && (pend_rd_q != '0) &&
                            (bus.RsD == pend_rd_q || bus.RtD == pend_rd_q);
  assign bus.op_count     = op_count_q;
  assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer: expected result destinations are queued at
// issue and checked by an independent monitor; a CNTW=4 copy checks saturation.
module tb_fpu_sequencer;

  localparam logic [4:0] FADD = 5'b00001;
  localparam logic [4:0] FMUL = 5'b00101;
  localparam logic [4:0] FDIV = 5'b00111;
  localparam logic [4:0] FNEG = 5'b01001;
  localparam logic [4:0] FMOV = 5'b01111;
  localparam logic [4:0] FTOI = 5'b10001;
  localparam logic [4:0] ITOF = 5'b10011;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  fpu_sequencer_if #(.REGW(6), .CNTW(16)) bus ();
  fpu_sequencer_if #(.REGW(6), .CNTW(4))  bus4 ();

  assign bus4.issue_valid = bus.issue_valid;
  assign bus4.issue_op    = bus.issue_op;
  assign bus4.issue_rd    = bus.issue_rd;
  assign bus4.flush       = bus.flush;
  assign bus4.RsD         = bus.RsD;
  assign bus4.RtD         = bus.RtD;

  fpu_sequencer #(.REGW(6), .CNTW(16)) dut  (.clk(clk), .rstn(rstn), .bus(bus));
  fpu_sequencer #(.REGW(6), .CNTW(4))  dut4 (.clk(clk), .rstn(rstn), .bus(bus4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and walk it to its DONE cycle; returns sampled at that DONE negedge.
  task automatic do_op(input logic [4:0] op, input logic [5:0] rd, input int lat);
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_rd    = rd;
    exp_q.push_back(int'(rd));
    @(negedge clk);
    check("op_issue_stall", bus.floatstall, 1);
    for (int k = 1; k < lat; k++) begin
      tick();
      bus.issue_valid = 1'b0;
      @(negedge clk);
      check("op_busy_stall", bus.floatstall, 1);
      check("op_busy_raw", bus.raw_hazard,
            (rd != 0 && (bus.RsD == rd || bus.RtD == rd)) ? 1 : 0);
    end
    tick();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    check("op_done_valid", bus.result_valid, 1);
    check("op_done_stall", bus.floatstall, 0);
  endtask

  // Scoreboard monitor: every result pulse must match the oldest queued destination.
  always @(negedge clk) begin
    if (bus.result_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got result_rd=%0d, expected no result pulse",
                 bus.result_rd);
      end else begin
        check("result_rd", bus.result_rd, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.issue_valid = 1'b1;
    bus.issue_op    = FADD;
    bus.issue_rd    = 6'd5;
    bus.flush       = 1'b0;
    bus.RsD         = '0;
    bus.RtD         = '0;
    #3;
    check("rst_floatstall", bus.floatstall, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_result_rd", bus.result_rd, 0);
    check("rst_raw", bus.raw_hazard, 0);
    check("rst_op_count", bus.op_count, 0);
    check("rst_stall_count", bus.stall_count, 0);
    bus.issue_valid = 1'b0;
    #19 rstn = 1'b1;

    // fadd rd=5: stall cycles 0-2, result in 3; later issue inputs ignored.
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_op    = FADD;
    bus.issue_rd    = 6'd5;
    exp_q.push_back(5);
    @(negedge clk);
    check("fadd_c0_stall", bus.floatstall, 1);
    check("fadd_c0_busy", bus.busy, 0);
    tick();
    bus.issue_op = FDIV;
    bus.issue_rd = 6'd9;
    @(negedge clk);
    check("fadd_c1_stall", bus.floatstall, 1);
    check("fadd_c1_busy", bus.busy, 1);
    tick();
    @(negedge clk);
    check("fadd_c2_stall", bus.floatstall, 1);
    tick();
    @(negedge clk);
    check("fadd_c3_stall", bus.floatstall, 0);
    check("fadd_c3_valid", bus.result_valid, 1);
    tick();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    check("fadd_op_count", bus.op_count, 1);
    check("fadd_stall_count", bus.stall_count, 3);
    check("fadd_idle", bus.busy, 0);

    // fdiv rd=7 with RsD=7, then ftoi rd=3 back-to-back.
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_op    = FDIV;
    bus.issue_rd    = 6'd7;
    bus.RsD         = 6'd7;
    exp_q.push_back(7);
    @(negedge clk);
    check("fdiv_c0_stall", bus.floatstall, 1);
    check("fdiv_c0_raw_idle", bus.raw_hazard, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      bus.issue_valid = 1'b0;
      @(negedge clk);
      check("fdiv_busy_raw", bus.raw_hazard, 1);
      check("fdiv_busy_stall", bus.floatstall, 1);
    end
    tick();
    @(negedge clk);
    check("fdiv_done_valid", bus.result_valid, 1);
    check("fdiv_done_stall", bus.floatstall, 0);
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_op    = FTOI;
    bus.issue_rd    = 6'd3;
    exp_q.push_back(3);
    @(negedge clk);
    check("ftoi_accept_stall", bus.floatstall, 1);
    check("ftoi_accept_raw", bus.raw_hazard, 0);
    tick();
    bus.issue_valid = 1'b0;
    bus.RsD         = '0;
    bus.RtD         = 6'd3;
    @(negedge clk);
    check("ftoi_done_valid", bus.result_valid, 1);
    check("ftoi_rt_raw", bus.raw_hazard, 1);
    tick();
    bus.RtD = '0;
    @(negedge clk);
    check("b2b_op_count", bus.op_count, 3);
    check("b2b_stall_count", bus.stall_count, 9);
    check("b2b_raw_idle", bus.raw_hazard, 0);

    // Zero-latency and unknown codes never stall.
    begin
      logic [4:0] zops[4];
      zops[0] = FNEG;
      zops[1] = FMOV;
      zops[2] = 5'b00000;
      zops[3] = 5'b11111;
      for (int i = 0; i < 4; i++) begin
        tick();
        bus.issue_valid = 1'b1;
        bus.issue_op    = zops[i];
        bus.issue_rd    = 6'd6;
        @(negedge clk);
        check("zero_stall", bus.floatstall, 0);
        check("zero_busy", bus.busy, 0);
      end
    end
    tick();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    check("zero_after_busy", bus.busy, 0);
    check("zero_op_count", bus.op_count, 3);
    check("zero_stall_count", bus.stall_count, 9);

    // fmul to r0: no RAW even though RsD/RtD are 0.
    do_op(FMUL, 6'd0, 2);
    tick();
    @(negedge clk);
    check("fmul_op_count", bus.op_count, 4);
    check("fmul_stall_count", bus.stall_count, 11);

    // Flush during fdiv cycle 2.
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_op    = FDIV;
    bus.issue_rd    = 6'd9;
    exp_q.push_back(9);
    @(negedge clk);
    check("flush_c0_stall", bus.floatstall, 1);
    tick();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    check("flush_c1_busy", bus.busy, 1);
    tick();
    bus.flush = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("flush_c2_stall", bus.floatstall, 1);
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", bus.busy, 0);
    check("flush_idle_stall", bus.floatstall, 0);
    repeat (6) tick();
    @(negedge clk);
    check("flush_op_count", bus.op_count, 4);
    check("flush_stall_count", bus.stall_count, 14);

    // Flush in DONE suppresses the pulse.
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_op    = ITOF;
    bus.issue_rd    = 6'd4;
    exp_q.push_back(4);
    @(negedge clk);
    check("itof_stall", bus.floatstall, 1);
    tick();
    bus.issue_valid = 1'b0;
    bus.flush       = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("flush_done_valid", bus.result_valid, 0);
    check("flush_done_busy", bus.busy, 1);
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_done_idle", bus.busy, 0);
    check("flush_done_op_count", bus.op_count, 4);

    // Flush on the accept cycle: stall shown, op not accepted.
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_op    = FADD;
    bus.issue_rd    = 6'd8;
    bus.flush       = 1'b1;
    @(negedge clk);
    check("flush_accept_stall", bus.floatstall, 1);
    tick();
    bus.issue_valid = 1'b0;
    bus.flush       = 1'b0;
    @(negedge clk);
    check("flush_accept_busy", bus.busy, 0);
    check("flush_accept_stall_count", bus.stall_count, 16);

    // Asynchronous reset in the middle of fmul.
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_op    = FMUL;
    bus.issue_rd    = 6'd2;
    exp_q.push_back(2);
    @(negedge clk);
    check("rmid_stall", bus.floatstall, 1);
    tick();
    bus.issue_valid = 1'b0;
    #2;
    rstn = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("rmid_floatstall", bus.floatstall, 0);
    check("rmid_busy", bus.busy, 0);
    check("rmid_result_valid", bus.result_valid, 0);
    check("rmid_op_count", bus.op_count, 0);
    check("rmid_stall_count", bus.stall_count, 0);
    @(negedge clk);
    #2 rstn = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("rmid_after_busy", bus.busy, 0);

    // Saturation on the CNTW=4 copy.
    for (int i = 0; i < 3; i++) do_op(FDIV, 6'd1, 5);
    check("sat3_stall4", bus4.stall_count, 15);
    check("sat3_stall16", bus.stall_count, 15);
    do_op(FDIV, 6'd1, 5);
    check("sat4_stall4", bus4.stall_count, 15);
    check("sat4_stall16", bus.stall_count, 20);
    for (int i = 0; i < 12; i++) do_op(FTOI, 6'd1, 1);
    tick();
    @(negedge clk);
    check("sat_op4", bus4.op_count, 15);
    check("sat_op16", bus.op_count, 16);
    check("sat_stall16_final", bus.stall_count, 32);
    check("sat_stall4_final", bus4.stall_count, 15);

    repeat (2) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
